// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C subordinate (and a future master).
//   i2c_state_e      - protocol state encoding
//   DEFAULT_SUB_ADDR - default 7-bit subordinate address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE_DATA,
    DATA_ACK,
    READ_DATA,
    MASTER_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_SUB_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers for SCL/SDA plus one extra stage
// used as the "previous" sample for edge and bus-condition detection.
//   clk_400, rst     - system clock, synchronous active-high reset
//   scl_in, sda_in   - raw bus lines
//   scl, sda         - synchronized levels
//   scl_rise/fall    - single-cycle SCL edge strobes
//   start_det/stop_det - SDA fall/rise while SCL high
module i2c_line_sync (
  input  logic clk_400,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] synchronizer, [2] previous synced value
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_in};
    sda_sync_d = {sda_sync_q[1:0], sda_in};
  end

  // Reset to the idle-bus level so leaving reset never looks like an edge
  always_ff @(posedge clk_400) begin
    if (rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
  assign start_det =  sda_sync_q[2] & ~sda_sync_q[1] & scl_sync_q[1];
  assign stop_det  = ~sda_sync_q[2] &  sda_sync_q[1] & scl_sync_q[1];

endmodule

// File: rtl/i2c_subordinate.sv
// i2c_subordinate: single-byte I2C subordinate (one write or one read per
// addressed transaction), no clock stretching.
//   clk_400, rst  - system clock (>= 8x SCL), synchronous active-high reset
//   SCL, SDA      - I2C bus; SCL only sampled, SDA pulled low or released
//   tx_data       - byte returned on a read, captured at address match
//   rx_data/rx_valid - last written byte and its one-cycle update strobe
//   addr_match    - address ACKed, until next START/STOP
//   master_nack   - master NACKed the read byte, until next START
//   busy          - state is not IDLE
module i2c_subordinate
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_SUB_ADDR
) (
  input  logic       clk_400,
  input  logic       rst,
  inout  tri         SCL,
  inout  tri         SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       master_nack,
  output logic       busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk_400   (clk_400),
    .rst       (rst),
    .scl_in    (SCL),
    .sda_in    (SDA),
    .scl       (scl_s),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_match_q, addr_match_d;
  logic       nack_q, nack_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    sda_oe_d     = sda_oe_q;
    rw_d         = rw_q;
    addr_match_d = addr_match_q;
    nack_d       = nack_q;
    load_d       = 1'b0;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;

    // Received byte lands one cycle after its 8th sample
    if (load_q) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end

    // Bus conditions win over any SCL edge in the same cycle
    if (start_det) begin
      state_d      = ADDR;
      cnt_d        = 4'd0;
      nack_d       = 1'b0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
    end else if (stop_det) begin
      state_d      = IDLE;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
    end else begin
      // All drive changes happen on SCL falls, so SDA is stable while SCL high
      case (state_q)
        ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d      = ADDR_ACK;
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              rw_d         = shift_q[0];
              if (shift_q[0]) tx_d = tx_data;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = READ_DATA;
              sda_oe_d = ~tx_q[7];
            end else begin
              state_d  = WRITE_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        WRITE_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            load_d  = (cnt_q == 4'd7);
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d  = DATA_ACK;
            sda_oe_d = 1'b1;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            state_d  = WAIT_STOP;
            sda_oe_d = 1'b0;
          end
        end
        READ_DATA: begin
          // Bit 7 went out when entering; each fall presents the next bit
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d  = MASTER_ACK;
              sda_oe_d = 1'b0;
            end else begin
              cnt_d    = cnt_q + 4'd1;
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        MASTER_ACK: begin
          if (scl_rise) begin
            nack_d  = sda_s;
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_400) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      shift_q      <= 8'h00;
      tx_q         <= 8'h00;
      rx_data_q    <= 8'h00;
      sda_oe_q     <= 1'b0;
      rw_q         <= 1'b0;
      load_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      rw_q         <= rw_d;
      load_q       <= load_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      nack_q       <= nack_d;
    end
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign addr_match  = addr_match_q;
  assign master_nack = nack_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_subordinate.sv
// tb_i2c_subordinate: directed I2C master transactions against the
// subordinate at address 0x42, SCL period 16 clk_400 cycles.
module tb_i2c_subordinate;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, addr_match, master_nack, busy;
  wire        scl, sda;

  always #5 clk = ~clk;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_subordinate #(.DEV_ADDR(7'h42)) dut (
    .clk_400     (clk),
    .rst         (rst),
    .SCL         (scl),
    .SDA         (sda),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .addr_match  (addr_match),
    .master_nack (master_nack),
    .busy        (busy)
  );

  int tests = 0;
  int fails = 0;
  int rxv_cnt = 0;  // cycles with rx_valid high
  int drv_cnt = 0;  // cycles SDA low while the master releases it

  always @(negedge clk) begin
    #2;
    if (rx_valid === 1'b1) rxv_cnt++;
    if (m_sda && sda === 1'b0) drv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting and ending with SCL low
  task automatic mbit(input logic b, output logic r);
    tick(4); m_sda = b;
    tick(4); m_scl = 1'b1;
    tick(4); r = sda;
    tick(4); m_scl = 1'b0;
  endtask

  task automatic mstart;
    tick(4); m_sda = 1'b1;
    tick(4); m_scl = 1'b1;
    tick(4); m_sda = 1'b0;
    tick(4); m_scl = 1'b0;
  endtask

  task automatic mstop;
    tick(4); m_sda = 1'b0;
    tick(4); m_scl = 1'b1;
    tick(4); m_sda = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) mbit(b[i], r);
    mbit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      mbit(1'b1, r);
      d[i] = r;
    end
    mbit(nack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         b_rx, b_drv;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_busy",   {7'd0, busy},        8'h00);
    chk("rst_match",  {7'd0, addr_match},  8'h00);
    chk("rst_valid",  {7'd0, rx_valid},    8'h00);
    chk("rst_nack",   {7'd0, master_nack}, 8'h00);
    chk("rst_rxdata", rx_data,             8'h00);
    chk("rst_sda",    {7'd0, sda},         8'h01);

    // Write 0xA5 to 0x42
    b_rx = rxv_cnt;
    mstart;
    send_byte(8'h84, ack);
    chk("wr_addr_ack", {7'd0, ack},        8'h00);
    chk("wr_match",    {7'd0, addr_match}, 8'h01);
    chk("wr_busy",     {7'd0, busy},       8'h01);
    send_byte(8'hA5, ack);
    chk("wr_data_ack", {7'd0, ack},        8'h00);
    chk("wr_rxdata",   rx_data,            8'hA5);
    chk("wr_rxvalid",  8'(rxv_cnt - b_rx), 8'h01);
    mstop; tick(4);
    chk("wr_idle",     {7'd0, busy},       8'h00);
    chk("wr_unmatch",  {7'd0, addr_match}, 8'h00);

    // Read 0x3C from 0x42, master NACKs
    tx_data = 8'h3C;
    mstart;
    send_byte(8'h85, ack);
    chk("rd_addr_ack", {7'd0, ack},         8'h00);
    read_byte(1'b1, d);
    chk("rd_byte",     d,                   8'h3C);
    chk("rd_nack",     {7'd0, master_nack}, 8'h01);
    mstop; tick(4);
    chk("rd_idle",     {7'd0, busy},        8'h00);
    chk("rd_nack_kept",{7'd0, master_nack}, 8'h01);

    // Write to 0x43: ignored
    b_rx = rxv_cnt; b_drv = drv_cnt;
    mstart;
    chk("mis_nack_clr", {7'd0, master_nack}, 8'h00);
    send_byte(8'h86, ack);
    chk("mis_addr_nak", {7'd0, ack},         8'h01);
    chk("mis_match",    {7'd0, addr_match},  8'h00);
    chk("mis_busy",     {7'd0, busy},        8'h01);
    send_byte(8'h11, ack);
    chk("mis_data_nak", {7'd0, ack},         8'h01);
    chk("mis_wait",     {7'd0, busy},        8'h01);
    mstop; tick(4);
    chk("mis_idle",     {7'd0, busy},        8'h00);
    chk("mis_rxvalid",  8'(rxv_cnt - b_rx),  8'h00);
    chk("mis_drive",    8'(drv_cnt - b_drv), 8'h00);

    // Repeated START after a write address, then read 0x96
    b_rx = rxv_cnt;
    tx_data = 8'h96;
    mstart;
    send_byte(8'h84, ack);
    chk("rs_addr1_ack", {7'd0, ack},         8'h00);
    mstart;
    chk("rs_match_clr", {7'd0, addr_match},  8'h00);
    send_byte(8'h85, ack);
    chk("rs_addr2_ack", {7'd0, ack},         8'h00);
    chk("rs_match",     {7'd0, addr_match},  8'h01);
    read_byte(1'b0, d);
    chk("rs_byte",      d,                   8'h96);
    chk("rs_ack",       {7'd0, master_nack}, 8'h00);
    mstop; tick(4);
    chk("rs_idle",      {7'd0, busy},        8'h00);
    chk("rs_rxvalid",   8'(rxv_cnt - b_rx),  8'h00);

    // Reset during data bit 4 of a write
    mstart;
    send_byte(8'h84, ack);
    chk("mr_addr_ack", {7'd0, ack}, 8'h00);
    mbit(1'b0, r); mbit(1'b1, r); mbit(1'b0, r);
    tick(4); m_sda = 1'b1;
    tick(4); m_scl = 1'b1;
    tick(2); rst = 1'b1;
    tick(1);
    chk("mr_sda",     {7'd0, sda},         8'h01);
    chk("mr_busy",    {7'd0, busy},        8'h00);
    chk("mr_match",   {7'd0, addr_match},  8'h00);
    chk("mr_valid",   {7'd0, rx_valid},    8'h00);
    chk("mr_rxdata",  rx_data,             8'h00);
    chk("mr_nack",    {7'd0, master_nack}, 8'h00);
    m_scl = 1'b0;
    tick(4); rst = 1'b0;
    mbit(1'b1, r); mbit(1'b0, r); mbit(1'b1, r); mbit(1'b0, r);
    mbit(1'b1, ack);
    chk("mr_no_resp", {7'd0, ack},  8'h01);
    chk("mr_still",   {7'd0, busy}, 8'h00);
    mstop;
    b_rx = rxv_cnt;
    mstart;
    send_byte(8'h84, ack);
    chk("mr2_addr_ack", {7'd0, ack},        8'h00);
    send_byte(8'h5A, ack);
    chk("mr2_data_ack", {7'd0, ack},        8'h00);
    chk("mr2_rxdata",   rx_data,            8'h5A);
    chk("mr2_rxvalid",  8'(rxv_cnt - b_rx), 8'h01);
    mstop; tick(4);
    chk("mr2_idle",     {7'd0, busy},       8'h00);

    // STOP after three address bits
    b_drv = drv_cnt;
    mstart;
    mbit(1'b1, r); mbit(1'b0, r); mbit(1'b0, r);
    chk("ps_busy",  {7'd0, busy},        8'h01);
    mstop; tick(4);
    chk("ps_idle",  {7'd0, busy},        8'h00);
    chk("ps_match", {7'd0, addr_match},  8'h00);
    chk("ps_drive", 8'(drv_cnt - b_drv), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
